// File: rtl/dac_sample_scheduler.sv
// Paces one synth-engine sample per DAC frame: period tick, req/valid fetch with timeout,
// and a boundary-only commit onto the DAC data bus with mute/disable and underrun counting.
module dac_sample_scheduler #(
  parameter int unsigned CLOCK_TICKS   = 1500,
  parameter int unsigned TIMEOUT_TICKS = 1000,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_mute,
  input  logic                   i_clear_count,
  output logic                   o_sample_req,
  input  logic                   i_sample_valid,
  input  logic [31:0]            i_sample,
  output logic                   o_sample_tick,
  output logic [31:0]            o_dac_data,
  output logic                   o_underrun,
  output logic [COUNT_WIDTH-1:0] o_underrun_count
);

  localparam int unsigned PERIOD_W  = (CLOCK_TICKS > 1) ? $clog2(CLOCK_TICKS) : 1;
  localparam int unsigned TIMEOUT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int unsigned SAMPLE_W  = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    REQUEST = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [PERIOD_W-1:0]    period_cnt;
  logic [TIMEOUT_W-1:0]   timeout_cnt;
  logic [SAMPLE_W-1:0]    pending;
  logic                   fresh;
  logic                   transfer;
  logic                   timeout;
  logic                   commit;

  // Free-running frame counter; tick is registered one count early so it lines up with CLOCK_TICKS-1.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      period_cnt    <= '0;
      o_sample_tick <= 1'b0;
    end else begin
      if (period_cnt == PERIOD_W'(CLOCK_TICKS - 1)) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + PERIOD_W'(1);
      end
      o_sample_tick <= (period_cnt == PERIOD_W'(CLOCK_TICKS - 2));
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Disable beats a same-cycle valid; a transfer beats a same-cycle timeout.
  always_comb begin
    state_next = state;
    transfer   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (o_sample_tick && i_enable) begin
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (!i_enable) begin
          state_next = IDLE;
        end else if (o_sample_req && i_sample_valid) begin
          transfer   = 1'b1;
          state_next = IDLE;
        end else if (timeout_cnt == TIMEOUT_W'(TIMEOUT_TICKS - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign commit = o_sample_tick && i_enable && !i_mute;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_sample_req <= 1'b0;
      timeout_cnt  <= '0;
      o_underrun   <= 1'b0;
    end else begin
      o_sample_req <= (state_next == REQUEST);
      o_underrun   <= timeout;
      if (state == IDLE) begin
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_underrun_count <= '0;
    end else if (i_clear_count) begin
      o_underrun_count <= '0;
    end else if (timeout && (o_underrun_count != {COUNT_WIDTH{1'b1}})) begin
      o_underrun_count <= o_underrun_count + COUNT_WIDTH'(1);
    end
  end

  // Pending is only written on transfer, never on a tick, so the commit read is always stable.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending    <= '0;
      fresh      <= 1'b0;
      o_dac_data <= '0;
    end else begin
      if (transfer) begin
        pending <= i_sample;
        fresh   <= 1'b1;
      end else if (commit && fresh) begin
        fresh <= 1'b0;
      end
      if (o_sample_tick) begin
        if (!i_enable || i_mute) begin
          o_dac_data <= '0;
        end else if (fresh) begin
          o_dac_data <= pending;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: one table row per sample period, plus an async-reset sequence.
module tb_dac_sample_scheduler;

  localparam int unsigned CT = 40;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = 4;
  localparam int          NV = 30;

  typedef struct {
    logic          en;
    logic          mute;
    int            dly;
    logic [31:0]   data;
    int            clr_at;
    int            drop_at;
    logic [31:0]   exp_dac;
    int            exp_req_len;
    int            exp_under;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic          i_mute;
  logic          i_clear_count;
  logic          o_sample_req;
  logic          i_sample_valid;
  logic [31:0]   i_sample;
  logic          o_sample_tick;
  logic [31:0]   o_dac_data;
  logic          o_underrun;
  logic [CW-1:0] o_underrun_count;

  int checks = 0;
  int errors = 0;
  vec_t vecs[NV];

  dac_sample_scheduler #(
    .CLOCK_TICKS  (CT),
    .TIMEOUT_TICKS(TO),
    .COUNT_WIDTH  (CW)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_enable        (i_enable),
    .i_mute          (i_mute),
    .i_clear_count   (i_clear_count),
    .o_sample_req    (o_sample_req),
    .i_sample_valid  (i_sample_valid),
    .i_sample        (i_sample),
    .o_sample_tick   (o_sample_tick),
    .o_dac_data      (o_dac_data),
    .o_underrun      (o_underrun),
    .o_underrun_count(o_underrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic mute, input int dly, input logic [31:0] data,
                              input int clr_at, input int drop_at, input logic [31:0] exp_dac,
                              input int exp_req_len, input int exp_under, input int exp_cnt);
    vec_t v;
    v.en = en; v.mute = mute; v.dly = dly; v.data = data;
    v.clr_at = clr_at; v.drop_at = drop_at; v.exp_dac = exp_dac;
    v.exp_req_len = exp_req_len; v.exp_under = exp_under; v.exp_cnt = CW'(exp_cnt);
    return v;
  endfunction

  // Starts on the negedge of a tick cycle and ends on the negedge of the next tick.
  task automatic run_period(input int idx, input vec_t v);
    int          reqlen = 0;
    int          unders = 0;
    int          drop_i = 0;
    logic        changed = 1'b0;
    logic        tick_early = 1'b0;
    logic [31:0] dac0 = '0;
    i_enable = v.en;
    i_mute   = v.mute;
    for (int i = 1; i <= int'(CT); i++) begin
      @(negedge clk);
      i_sample_valid = 1'b0;
      i_clear_count  = 1'b0;
      if (i == 1) begin
        check($sformatf("v%0d dac_commit", idx), o_dac_data, v.exp_dac);
        check($sformatf("v%0d req_start", idx), 32'(o_sample_req), 32'(v.en));
        dac0 = o_dac_data;
      end else if (o_dac_data !== dac0) begin
        changed = 1'b1;
      end
      if (o_sample_req) begin
        reqlen++;
        if (reqlen == v.dly) begin
          i_sample_valid = 1'b1;
          i_sample       = v.data;
        end
        if (reqlen == v.clr_at) i_clear_count = 1'b1;
        if (reqlen == v.drop_at) begin
          i_enable = 1'b0;
          drop_i   = i;
        end
      end
      if (drop_i != 0 && i == drop_i + 1) begin
        i_sample_valid = 1'b1;
        i_sample       = 32'hBAD0_0BAD;
      end
      if (i == 35) begin
        i_sample_valid = 1'b1;
        i_sample       = 32'hDEAD_BEEF;
      end
      if (o_underrun) unders++;
      if (i < int'(CT) && o_sample_tick) tick_early = 1'b1;
    end
    check($sformatf("v%0d tick_period", idx), {31'b0, o_sample_tick && !tick_early}, 32'd1);
    check($sformatf("v%0d dac_stable", idx), 32'(changed), 32'd0);
    check($sformatf("v%0d req_len", idx), reqlen, v.exp_req_len);
    check($sformatf("v%0d underruns", idx), unders, v.exp_under);
    check($sformatf("v%0d count", idx), 32'(o_underrun_count), 32'(v.exp_cnt));
  endtask

  task automatic wait_first_tick(input string name);
    int n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (o_sample_tick) begin
        n = k;
        break;
      end
    end
    check(name, n, CT - 1);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 5,  32'h1234_5678, 0,  0, 32'h0,          5,  0, 0);
    vecs[1]  = mk(1, 0, 0,  32'h0,         0,  0, 32'h1234_5678,  20, 1, 1);
    vecs[2]  = mk(1, 0, 20, 32'hCAFE_F00D, 0,  0, 32'h1234_5678,  20, 0, 1);
    vecs[3]  = mk(1, 0, 1,  32'h0000_0001, 0,  0, 32'hCAFE_F00D,  1,  0, 1);
    vecs[4]  = mk(1, 1, 3,  32'hAAAA_5555, 0,  0, 32'h0,          3,  0, 1);
    vecs[5]  = mk(1, 1, 2,  32'h1111_2222, 0,  0, 32'h0,          2,  0, 1);
    vecs[6]  = mk(1, 0, 4,  32'h3333_4444, 0,  0, 32'h1111_2222,  4,  0, 1);
    vecs[7]  = mk(0, 0, 0,  32'h0,         0,  0, 32'h0,          0,  0, 1);
    vecs[8]  = mk(1, 0, 0,  32'h0,         0,  0, 32'h3333_4444,  20, 1, 2);
    vecs[9]  = mk(1, 0, 7,  32'h0000_0077, 3,  0, 32'h3333_4444,  7,  0, 0);
    vecs[10] = mk(1, 0, 0,  32'h0,         20, 0, 32'h0000_0077,  20, 1, 0);
    vecs[11] = mk(1, 0, 0,  32'h0,         0,  4, 32'h0000_0077,  4,  0, 0);
    vecs[12] = mk(0, 0, 0,  32'h0,         0,  0, 32'h0,          0,  0, 0);
    vecs[13] = mk(1, 0, 0,  32'h0,         0,  0, 32'h0,          20, 1, 1);
    for (int i = 14; i <= 28; i++) begin
      vecs[i] = mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 20, 1, (i - 12 > 15) ? 15 : i - 12);
    end
    vecs[29] = mk(1, 0, 2,  32'h5A5A_0001, 0,  0, 32'h0,          2,  0, 15);

    rst_n          = 1'b0;
    i_enable       = 1'b0;
    i_mute         = 1'b0;
    i_clear_count  = 1'b0;
    i_sample_valid = 1'b0;
    i_sample       = '0;
    repeat (3) @(negedge clk);
    check("rst req", 32'(o_sample_req), 32'd0);
    check("rst tick", 32'(o_sample_tick), 32'd0);
    check("rst dac", o_dac_data, 32'd0);
    check("rst underrun", 32'(o_underrun), 32'd0);
    check("rst count", 32'(o_underrun_count), 32'd0);
    rst_n    = 1'b1;
    i_enable = 1'b1;
    wait_first_tick("first_tick_delay");

    for (int i = 0; i < NV; i++) run_period(i, vecs[i]);

    // Async reset in the middle of a request, with a committed sample and saturated count.
    i_enable = 1'b1;
    i_mute   = 1'b0;
    @(negedge clk);
    check("pre_rst dac", o_dac_data, 32'h5A5A_0001);
    check("pre_rst req", 32'(o_sample_req), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst req", 32'(o_sample_req), 32'd0);
    check("async_rst dac", o_dac_data, 32'd0);
    check("async_rst count", 32'(o_underrun_count), 32'd0);
    check("async_rst underrun", 32'(o_underrun), 32'd0);
    check("async_rst tick", 32'(o_sample_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_first_tick("post_rst_tick_delay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
